// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and default width for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEFAULT_OPERAND_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {acc, q} register pair.
// The divide path exists only when MULDIV_DIVIDE_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = DEFAULT_OPERAND_WIDTH
) (
`ifdef MULDIV_DIVIDE_EN
  input  logic                     is_div,
`endif
  input  logic [OPERAND_WIDTH-1:0] acc_i,
  input  logic [OPERAND_WIDTH-1:0] q_i,
  input  logic [OPERAND_WIDTH-1:0] m_i,
  output logic [OPERAND_WIDTH-1:0] acc_o,
  output logic [OPERAND_WIDTH-1:0] q_o
);

  localparam int unsigned W = OPERAND_WIDTH;

  logic [W:0] sum;
`ifdef MULDIV_DIVIDE_EN
  logic [W:0]   shifted;
  logic [W-1:0] diff;
`endif

  always_comb begin
    // Multiply: add multiplicand when the low multiplier bit is set, then shift the pair right.
    sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
    acc_o = sum[W:1];
    q_o   = {sum[0], q_i[W-1:1]};
`ifdef MULDIV_DIVIDE_EN
    shifted = {acc_i, q_i[W-1]};
    diff    = shifted[W-1:0] - m_i;
    if (is_div) begin
      if (shifted >= {1'b0, m_i}) begin
        acc_o = diff;
        q_o   = {q_i[W-2:0], 1'b1};
      end else begin
        acc_o = shifted[W-1:0];
        q_o   = {q_i[W-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/iterative_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO registers.
// Define MULDIV_DIVIDE_EN to build the divider; otherwise DIV/DIVU report an illegal op.
module iterative_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = DEFAULT_OPERAND_WIDTH,
  parameter int unsigned CNT_WIDTH     = $clog2(OPERAND_WIDTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [2:0]               Op,
  input  logic [OPERAND_WIDTH-1:0] Operand1,
  input  logic [OPERAND_WIDTH-1:0] Operand2,
  output logic                     Busy,
  output logic                     Done,
  output logic [OPERAND_WIDTH-1:0] HI_OUT,
  output logic [OPERAND_WIDTH-1:0] LO_OUT,
  output logic                     DZ_OUT,
  output logic                     BF_OUT
);

  localparam int unsigned W = OPERAND_WIDTH;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [W-1:0]         acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 neg_res_q, neg_res_d;
  logic                 dz_pend_q, dz_pend_d, bf_pend_q, bf_pend_d;
  logic                 done_q, done_d, dz_q, dz_d, bf_q, bf_d;
`ifdef MULDIV_DIVIDE_EN
  logic                 neg_rem_q, neg_rem_d;
`endif

  logic         sgn, s1, s2;
  logic [W-1:0] abs1, abs2, step_acc, step_q;
  logic [2*W-1:0] prod;

  muldiv_step #(.OPERAND_WIDTH(W)) u_step (
`ifdef MULDIV_DIVIDE_EN
    .is_div (op_q[1]),
`endif
    .acc_i  (acc_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    dz_pend_d = dz_pend_q;
    bf_pend_d = bf_pend_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    bf_d      = 1'b0;
`ifdef MULDIV_DIVIDE_EN
    neg_rem_d = neg_rem_q;
`endif
    prod = {acc_q, q_q};
    sgn  = ~Op[2] & ~Op[0];
    s1   = sgn & Operand1[W-1];
    s2   = sgn & Operand2[W-1];
    abs1 = s1 ? -Operand1 : Operand1;
    abs2 = s2 ? -Operand2 : Operand2;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d      = Op;
          cnt_d     = '0;
          acc_d     = '0;
          neg_res_d = 1'b0;
          dz_pend_d = 1'b0;
          bf_pend_d = 1'b0;
          state_d   = ST_FIN;
          case (Op)
            OP_MULT, OP_MULTU: begin
              m_d       = abs1;
              q_d       = abs2;
              neg_res_d = s1 ^ s2;
              state_d   = ST_RUN;
            end
`ifdef MULDIV_DIVIDE_EN
            OP_DIV, OP_DIVU: begin
              if (Operand2 == '0) begin
                dz_pend_d = 1'b1;
              end else begin
                q_d       = abs1;
                m_d       = abs2;
                neg_res_d = s1 ^ s2;
                neg_rem_d = s1;
                state_d   = ST_RUN;
              end
            end
`endif
            OP_MTHI, OP_MTLO: q_d = Operand1;
            default:          bf_pend_d = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(W - 1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        dz_d    = dz_pend_q;
        bf_d    = bf_pend_q;
        if (!(dz_pend_q || bf_pend_q)) begin
          case (op_q)
            OP_MULT, OP_MULTU: begin
              if (neg_res_q) prod = -prod;
              hi_d = prod[2*W-1:W];
              lo_d = prod[W-1:0];
            end
`ifdef MULDIV_DIVIDE_EN
            // Quotient takes the XOR of operand signs, remainder the dividend's sign.
            OP_DIV, OP_DIVU: begin
              lo_d = neg_res_q ? -q_q : q_q;
              hi_d = neg_rem_q ? -acc_q : acc_q;
            end
`endif
            OP_MTHI: hi_d = q_q;
            OP_MTLO: lo_d = q_q;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      dz_pend_q <= 1'b0;
      bf_pend_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      bf_q      <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      dz_pend_q <= dz_pend_d;
      bf_pend_q <= bf_pend_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      bf_q      <= bf_d;
`ifdef MULDIV_DIVIDE_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign Done   = done_q;
  assign DZ_OUT = dz_q;
  assign BF_OUT = bf_q;
  assign HI_OUT = hi_q;
  assign LO_OUT = lo_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed self-checking bench for iterative_muldiv_unit at the default 32-bit width.
module tb_iterative_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic        Busy, Done, DZ_OUT, BF_OUT;
  logic [31:0] HI_OUT, LO_OUT;

  int pass_cnt = 0;
  int total    = 0;

  iterative_muldiv_unit #(.OPERAND_WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Start    (Start),
    .Op       (Op),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Busy     (Busy),
    .Done     (Done),
    .HI_OUT   (HI_OUT),
    .LO_OUT   (LO_OUT),
    .DZ_OUT   (DZ_OUT),
    .BF_OUT   (BF_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation from the current (idle or Done) cycle and wait for Done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat, output int busy_cyc);
    int k;
    Start = 1'b1; Op = op; Operand1 = a; Operand2 = b;
    @(posedge CLK); #1;
    Start = 1'b0; Op = 3'b110; Operand1 = 32'hA5A5A5A5; Operand2 = 32'h5A5A5A5A;
    k = 0; busy_cyc = 0;
    while (!Done && k < 100) begin
      if (Busy) busy_cyc++;
      if (inject && k == 5) begin
        Start = 1'b1; Op = 3'b100; Operand1 = 32'hDEADBEEF;
      end else if (inject && k == 6) begin
        Start = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
    end
    lat = k + 1;
    chk("done_seen", {63'd0, Done}, 64'd1);
  endtask

  int  lat, bc;
  bit  saw_done;

  initial begin
    #2;
    chk("reset_flags", {60'd0, Busy, Done, DZ_OUT, BF_OUT}, 64'd0);
    chk("reset_hilo", {HI_OUT, LO_OUT}, 64'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
    chk("multu_max_hilo", {HI_OUT, LO_OUT}, 64'hFFFFFFFE_00000001);
    chk("multu_latency", 64'(lat), 64'd34);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_flags", {62'd0, DZ_OUT, BF_OUT}, 64'd0);
    @(posedge CLK); #1;
    chk("done_one_cycle", {63'd0, Done}, 64'd0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd7, 1'b0, lat, bc);
    chk("mult_neg_hilo", {HI_OUT, LO_OUT}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mult_latency", 64'(lat), 64'd34);

    run_op(3'b100, 32'h12345678, 32'h0, 1'b0, lat, bc);
    chk("mthi_hilo", {HI_OUT, LO_OUT}, 64'h12345678_FFFFFFEB);
    chk("mthi_latency", 64'(lat), 64'd2);
    run_op(3'b101, 32'h9ABCDEF0, 32'h0, 1'b0, lat, bc);
    chk("mtlo_hilo", {HI_OUT, LO_OUT}, 64'h12345678_9ABCDEF0);
    chk("mtlo_latency", 64'(lat), 64'd2);

    run_op(3'b111, 32'h1, 32'h2, 1'b0, lat, bc);
    chk("illegal_flags", {62'd0, DZ_OUT, BF_OUT}, 64'd1);
    chk("illegal_hilo", {HI_OUT, LO_OUT}, 64'h12345678_9ABCDEF0);
    chk("illegal_latency", 64'(lat), 64'd2);

`ifdef MULDIV_DIVIDE_EN
    run_op(3'b011, 32'd7, 32'd0, 1'b0, lat, bc);
    chk("divu_zero_flags", {62'd0, DZ_OUT, BF_OUT}, 64'd2);
    chk("divu_zero_hilo", {HI_OUT, LO_OUT}, 64'h12345678_9ABCDEF0);
    chk("divu_zero_latency", 64'(lat), 64'd2);

    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bc);
    chk("div_neg_hilo", {HI_OUT, LO_OUT}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_latency", 64'(lat), 64'd34);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc);
    chk("div_ovf_hilo", {HI_OUT, LO_OUT}, 64'h00000000_80000000);
    chk("div_ovf_flags", {62'd0, DZ_OUT, BF_OUT}, 64'd0);

    run_op(3'b011, 32'd100, 32'd7, 1'b0, lat, bc);
    chk("divu_hilo", {HI_OUT, LO_OUT}, 64'h00000002_0000000E);
`else
    run_op(3'b011, 32'd10, 32'd3, 1'b0, lat, bc);
    chk("divu_absent_flags", {62'd0, DZ_OUT, BF_OUT}, 64'd1);
    chk("divu_absent_hilo", {HI_OUT, LO_OUT}, 64'h12345678_9ABCDEF0);
    chk("divu_absent_latency", 64'(lat), 64'd2);
`endif

    run_op(3'b001, 32'd5, 32'd6, 1'b1, lat, bc);
    chk("ignored_start_hilo", {HI_OUT, LO_OUT}, 64'h00000000_0000001E);
    chk("ignored_start_latency", 64'(lat), 64'd34);
    @(posedge CLK); #1;
    chk("ignored_start_no_queue", {62'd0, Busy, Done}, 64'd0);

    Start = 1'b1; Op = 3'b001; Operand1 = 32'd9; Operand2 = 32'd9;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_state", {62'd0, Busy, Done}, 64'd0);
    chk("abort_hilo", {HI_OUT, LO_OUT}, 64'd0);
    @(negedge CLK); RST = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (Done || Busy) saw_done = 1'b1;
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'd0);

    run_op(3'b001, 32'd3, 32'd4, 1'b0, lat, bc);
    chk("post_reset_hilo", {HI_OUT, LO_OUT}, 64'h00000000_0000000C);
    chk("post_reset_latency", 64'(lat), 64'd34);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
